// File: rtl/targ_fb_sched.sv
// Target-predictor feedback scheduler: round-robin lane arbiter, tail-coalescing
// feedback FIFO, single-port issue, and post-reset table-clear sequencing.

package sys;
    typedef logic        bool_t;
    typedef logic [31:0] addr_t;
endpackage

package core;
    localparam int peval_width = 4;
    typedef struct packed {
        logic       valid;
        sys::addr_t base_pc;
        sys::addr_t targ_pc;
    } targ_pred_fb_t;
endpackage

module targ_fb_sched
    import sys::*;
#(
    parameter int fifo_depth = 4,
    parameter int cnt_width  = 16
) (
    input  logic                               clk,
    input  bool_t                              rst,
    input  bool_t [core::peval_width-1:0]      res_valid,
    input  sys::addr_t [core::peval_width-1:0] res_base_pc,
    input  sys::addr_t [core::peval_width-1:0] res_targ_pc,
    output bool_t [core::peval_width-1:0]      res_ready,
    input  bool_t                              flush,
    input  bool_t                              drain_req,
    output bool_t                              drain_done,
    input  bool_t                              pred_stall,
    output core::targ_pred_fb_t                fb,
    output bool_t                              pred_en,
    output bool_t                              pred_rst,
    output logic [cnt_width-1:0]               coalesce_cnt
);
    localparam int NL = core::peval_width;
    localparam int AW = $clog2(fifo_depth);
    localparam int LW = (NL > 1) ? $clog2(NL) : 1;
    localparam int AD = $bits(sys::addr_t);
    localparam int EW = 2 * AD;

    typedef enum logic [1:0] {S_INIT, S_RUN, S_DRAIN} state_e;

    state_e          state_q, state_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [cnt_width-1:0] cnt_q, cnt_d;
    logic [EW-1:0]   mem_q [fifo_depth];

    logic            empty, full, pop, push, grant, can_accept, coalesce, gnt_any;
    logic [LW-1:0]   gnt_idx;
    logic [AW-1:0]   tail_idx;
    logic [EW-1:0]   gnt_entry, head_entry;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign tail_idx   = wr_ptr_q[AW-1:0] - AW'(1);
    assign head_entry = mem_q[rd_ptr_q[AW-1:0]];

    // Issue: head leaves whenever the predictor can take it; flush blocks it.
    assign pop      = !empty && !pred_stall && (state_q != S_INIT) && !flush;
    assign fb.valid = pop;
    assign fb.base_pc = head_entry[EW-1:AD];
    assign fb.targ_pc = head_entry[AD-1:0];
    assign pred_en  = (state_q == S_INIT) || pop;
    assign pred_rst = (state_q == S_INIT);
    assign drain_done   = (state_q == S_DRAIN) && empty;
    assign coalesce_cnt = cnt_q;

    // Round-robin search: first valid lane at or after rr_ptr, lowest offset wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NL - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NL;
            if (res_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = LW'(idx);
            end
        end
    end

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign can_accept = (state_q == S_RUN) && !drain_req && !flush && (!full || pop);
    assign grant      = can_accept && gnt_any;
    assign gnt_entry  = {res_base_pc[gnt_idx], res_targ_pc[gnt_idx]};
    // Tail compare still applies if that tail is the head popping this cycle.
    assign coalesce   = !empty && (gnt_entry == mem_q[tail_idx]);
    assign push       = grant && !coalesce;

    // One-hot acceptance back to the lanes.
    always_comb begin
        res_ready = '0;
        if (grant) res_ready[gnt_idx] = 1'b1;
    end

    // Next-state: FSM, FIFO pointers, arbiter pointer, coalesce statistic.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            case (state_q)
                S_INIT:  state_d = S_RUN;
                S_RUN:   if (drain_req) state_d = S_DRAIN;
                S_DRAIN: if (!drain_req) state_d = S_RUN;
                default: state_d = S_INIT;
            endcase
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (grant) rr_ptr_d = (int'(gnt_idx) == NL - 1) ? '0 : gnt_idx + 1'b1;
            if (grant && coalesce && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset drops all queued events at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_INIT;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= gnt_entry;
    end
endmodule

// File: tb/tb_targ_fb_sched.sv
// Directed bench for targ_fb_sched: reset/INIT, round-robin order, stall and
// back-pressure, coalescing, drain, flush, and mid-run reset.
module tb_targ_fb_sched;
    logic                   clk = 1'b0;
    logic                   rst;
    logic [3:0]             res_valid;
    logic [3:0][31:0]       res_base_pc, res_targ_pc;
    logic [3:0]             res_ready;
    logic                   flush, drain_req, drain_done, pred_stall, pred_en, pred_rst;
    core::targ_pred_fb_t    fb;
    logic [15:0]            coalesce_cnt;

    int total = 0, passed = 0, fails = 0, grants;

    always #5 clk = ~clk;

    targ_fb_sched #(.fifo_depth(4), .cnt_width(16)) dut (
        .clk(clk), .rst(rst), .res_valid(res_valid), .res_base_pc(res_base_pc),
        .res_targ_pc(res_targ_pc), .res_ready(res_ready), .flush(flush),
        .drain_req(drain_req), .drain_done(drain_done), .pred_stall(pred_stall),
        .fb(fb), .pred_en(pred_en), .pred_rst(pred_rst), .coalesce_cnt(coalesce_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Lane i presents base = b + i, targ = base + 0x10000.
    task automatic drive(input logic [3:0] v, input logic [31:0] b);
        res_valid = v;
        for (int i = 0; i < 4; i++) begin
            res_base_pc[i] = b + 32'(i);
            res_targ_pc[i] = b + 32'(i) + 32'h10000;
        end
    endtask

    task automatic chk_fb(input string tag, input logic [31:0] base);
        chk({tag, ".v"}, 64'(fb.valid), 64'd1);
        chk({tag, ".base"}, 64'(fb.base_pc), 64'(base));
        chk({tag, ".targ"}, 64'(fb.targ_pc), 64'(base + 32'h10000));
        chk({tag, ".en"}, 64'(pred_en), 64'd1);
    endtask

    task automatic next_cyc;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; flush = 0; drain_req = 0; pred_stall = 0;
        drive(4'hF, 32'h0);
        next_cyc; next_cyc;
        #3;
        chk("rst.pred_rst", 64'(pred_rst), 1);
        chk("rst.pred_en", 64'(pred_en), 1);
        chk("rst.ready", 64'(res_ready), 0);
        chk("rst.fbv", 64'(fb.valid), 0);
        chk("rst.drain_done", 64'(drain_done), 0);
        chk("rst.cnt", 64'(coalesce_cnt), 0);
        // cycle 0: INIT
        rst = 1'b0;
        #3;
        chk("c0.pred_rst", 64'(pred_rst), 1);
        chk("c0.ready", 64'(res_ready), 0);
        next_cyc;

        // Round robin, all lanes valid, distinct PCs per cycle
        for (int c = 1; c <= 5; c++) begin
            drive(4'hF, 32'h1000 + 32'(c * 16));
            #3;
            chk("rr.ready", 64'(res_ready), 64'(4'b1 << ((c - 1) % 4)));
            chk("rr.pred_rst", 64'(pred_rst), 0);
            if (c > 1) chk_fb("rr.fb", 32'h1000 + 32'((c - 1) * 16 + (c - 2) % 4));
            else chk("rr.fb0", 64'(fb.valid), 0);
            next_cyc;
        end
        drive(4'h0, 32'h0); #3;
        chk_fb("rr.fb_last", 32'h1050);
        next_cyc; #3;
        chk("rr.idle_v", 64'(fb.valid), 0);
        chk("rr.idle_en", 64'(pred_en), 0);
        next_cyc;

        // Stall with lane 0 streaming: 4 grants then back-pressure
        grants = 0;
        pred_stall = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(4'b0001, 32'h3000 + 32'(k * 16));
            #3;
            chk("st.ready", 64'(res_ready), (k < 4) ? 64'd1 : 64'd0);
            chk("st.fbv", 64'(fb.valid), 0);
            grants += int'(res_ready[0]);
            next_cyc;
        end
        chk("st.grants", 64'(grants), 4);
        pred_stall = 1'b0;
        drive(4'b0001, 32'h30a0); #3;
        chk("st.rel_ready", 64'(res_ready), 1);
        chk_fb("st.fb0", 32'h3000);
        next_cyc;
        drive(4'h0, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            #3; chk_fb("st.fb", 32'h3000 + 32'(k * 16)); next_cyc;
        end
        #3; chk_fb("st.fb_new", 32'h30a0); next_cyc;
        #3; chk("st.empty", 64'(fb.valid), 0); next_cyc;

        // Coalesce: lane 1 repeats {0x100,0x200} three times while stalled
        pred_stall = 1'b1;
        for (int j = 0; j < 3; j++) begin
            res_valid = 4'b0010;
            res_base_pc[1] = 32'h100; res_targ_pc[1] = 32'h200;
            #3;
            chk("co.ready", 64'(res_ready), 64'b0010);
            chk("co.cnt", 64'(coalesce_cnt), 64'((j > 0) ? j - 1 : 0));
            next_cyc;
        end
        pred_stall = 1'b0; res_valid = 4'h0; #3;
        chk("co.cnt2", 64'(coalesce_cnt), 2);
        chk("co.fbv", 64'(fb.valid), 1);
        chk("co.fbb", 64'(fb.base_pc), 64'h100);
        chk("co.fbt", 64'(fb.targ_pc), 64'h200);
        next_cyc; #3;
        chk("co.one", 64'(fb.valid), 0);
        next_cyc;

        // Drain: queue three on lane 2 (rr now 2)
        pred_stall = 1'b1;
        for (int j = 0; j < 3; j++) begin
            drive(4'b0100, 32'h500 + 32'(j * 16)); #3;
            chk("dr.q_ready", 64'(res_ready), 64'b0100);
            next_cyc;
        end
        pred_stall = 1'b0; drain_req = 1'b1; drive(4'hF, 32'h700);
        for (int j = 0; j < 3; j++) begin
            #3;
            chk("dr.ready", 64'(res_ready), 0);
            chk("dr.done0", 64'(drain_done), 0);
            chk_fb("dr.fb", 32'h502 + 32'(j * 16));
            next_cyc;
        end
        #3;
        chk("dr.ready3", 64'(res_ready), 0);
        chk("dr.fbv3", 64'(fb.valid), 0);
        chk("dr.done", 64'(drain_done), 1);
        next_cyc;
        drain_req = 1'b0; #3;
        chk("dr.exit_ready", 64'(res_ready), 0);
        chk("dr.exit_done", 64'(drain_done), 1);
        next_cyc;
        pred_stall = 1'b1; drive(4'hF, 32'h800); #3;
        chk("dr.resume", 64'(res_ready), 64'b1000);
        chk("dr.done_clr", 64'(drain_done), 0);
        next_cyc;

        // Fill FIFO then flush
        for (int k = 0; k < 3; k++) begin
            drive(4'hF, 32'h900 + 32'(k * 16)); #3;
            chk("fl.fill", 64'(res_ready), 64'(4'b1 << k));
            next_cyc;
        end
        pred_stall = 1'b0; flush = 1'b1; drive(4'hF, 32'hA00); #3;
        chk("fl.ready", 64'(res_ready), 0);
        chk("fl.fbv", 64'(fb.valid), 0);
        chk("fl.en", 64'(pred_en), 0);
        next_cyc;
        flush = 1'b0; drive(4'hF, 32'hB00); #3;
        chk("fl.empty", 64'(fb.valid), 0);
        chk("fl.rr_kept", 64'(res_ready), 64'b1000);
        chk("fl.cnt_kept", 64'(coalesce_cnt), 2);
        next_cyc;
        drive(4'h0, 32'h0); #3;
        chk_fb("fl.fb_after", 32'hB03);
        next_cyc;

        // Reset mid-run with an entry queued
        pred_stall = 1'b1; drive(4'hF, 32'hC00); next_cyc;
        pred_stall = 1'b0; drive(4'h0, 32'h0); rst = 1'b1; #1;
        chk("mr.fbv", 64'(fb.valid), 0);
        chk("mr.pred_rst", 64'(pred_rst), 1);
        chk("mr.cnt", 64'(coalesce_cnt), 0);
        chk("mr.ready", 64'(res_ready), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/targ_fb_sched.md
# targ_fb_sched

Feedback scheduler for the target predictor. It collects branch-target resolutions from the `core::peval_width` parallel evaluation lanes and grants one lane per cycle round-robin. Accepted events are buffered in a small FIFO, and duplicates are coalesced against the FIFO tail. Events are issued to the predictor's single `core::targ_pred_fb_t` feedback port at one per cycle. It also sequences the predictor's table clear after reset and supports flush and drain.

## Interface
Parameters:
- `fifo_depth`, 4: feedback FIFO entries; power of two, at least 2.
- `cnt_width`, 16: width of the coalesce statistic counter.

Ports:
- `clk` in 1: clock.
- `rst` in `bool_t`: reset, asynchronous, active-high.
- `res_valid` in `bool_t [core::peval_width]`: lane i has a resolved branch this cycle.
- `res_base_pc` in `sys::addr_t [core::peval_width]`: lane i branch PC.
- `res_targ_pc` in `sys::addr_t [core::peval_width]`: lane i resolved target.
- `res_ready` out `bool_t [core::peval_width]`: one-hot grant; lane i event accepted this cycle.
- `flush` in `bool_t`: discard all queued feedback.
- `drain_req` in `bool_t`: level; stop accepting, emit the queue.
- `drain_done` out `bool_t`: drain in progress and FIFO empty.
- `pred_stall` in `bool_t`: predictor may not take feedback this cycle.
- `fb` out `core::targ_pred_fb_t`: feedback to the predictor.
- `pred_en` out `bool_t`: predictor enable.
- `pred_rst` out `bool_t`: predictor synchronous table clear.
- `coalesce_cnt` out `cnt_width`: saturating count of coalesced (dropped) events.

## Operation
- FSM states: INIT, RUN, DRAIN. Asynchronous reset forces INIT.
- INIT:
  - `pred_rst`=1, `pred_en`=1, all `res_ready`=0, `fb.valid`=0.
  - Lasts exactly one cycle after reset deasserts, then goes to RUN.
- RUN:
  - Arbiter: among lanes with `res_valid`, the grant goes to the first at or after `rr_ptr`, wrapping modulo `peval_width`.
  - After a grant to lane g, `rr_ptr` becomes g+1 mod `peval_width`. With no grant, `rr_ptr` is unchanged.
  - No grant is issued when the FIFO is full and no pop occurs this cycle. A pop in the same cycle frees a slot, so push and pop may coexist.
  - Coalesce: if the FIFO is non-empty and the granted {base_pc, targ_pc} equals the tail entry, the event is not pushed. `res_ready` is still asserted and `coalesce_cnt` increments, saturating at all-ones.
  - Coalescing also applies when the tail entry is popped in the same cycle.
  - `drain_req`=1 moves RUN to DRAIN. No grant is issued in the cycle `drain_req` is sampled.
- DRAIN:
  - `res_ready`=0, and issue continues.
  - `drain_done`=1 when the FIFO is empty.
  - `drain_req`=0 returns the FSM to RUN.
- Issue:
  - `fb.valid`=1 iff the FIFO is non-empty, `pred_stall`=0, and the state is not INIT.
  - `fb.base_pc` and `fb.targ_pc` come from the FIFO head. The head pops on every cycle `fb.valid`=1.
  - `pred_en` = (state==INIT) | `fb.valid`, so the predictor table updates only on real feedback.
- Flush:
  - Empties the FIFO at the next edge and suppresses grants and issue in the cycle `flush` is high (`res_ready`=0, `fb.valid`=0).
  - Retains `rr_ptr`, `coalesce_cnt`, and the FSM state.
  - Flush wins over every other event.
- Pointers are `$clog2(fifo_depth)`+1 bits. Full when the index bits are equal and the wrap bits differ.

## Timing
- Reset values: state INIT, FIFO empty, `rr_ptr`=0, `coalesce_cnt`=0, `fb.valid`=0, `res_ready`=0, `drain_done`=0, `pred_rst`=1, `pred_en`=1.
- `res_ready` is combinational from `res_valid`, FIFO state, and `pred_stall`.
- An event accepted in cycle N appears on `fb` no earlier than cycle N+1. The FIFO has no bypass.
- Throughput: 1 event/cycle in and 1 event/cycle out.
- `fb` and `pred_en` are combinational from FIFO state and `pred_stall`.
- Reset asserted mid-operation: all queued events are lost immediately; no partial feedback is issued.
- Drain entered while `pred_stall`=1: `drain_done` stays 0 until the FIFO actually empties.

## Test plan
- Reset release: `pred_rst`=1 in cycle 0 only, then 0; `res_ready` stays 0 in cycle 0; first grant possible in cycle 1.
- All lanes valid every cycle with distinct PCs, `peval_width`=4: grants go 0,1,2,3,0 in consecutive cycles; `fb` emits the same order starting one cycle later, with one `pred_en` pulse per event.
- `pred_stall`=1 for 10 cycles with lane 0 streaming distinct events: exactly `fifo_depth` grants, then `res_ready`=0. On release, `fifo_depth` feedback cycles are issued in order, and grants resume in the first release cycle.
- Lane 1 presents {0x100, 0x200} three times with the FIFO stalled: one entry queued, `coalesce_cnt`=2, and one `fb` after the stall is released.
- Three entries queued, `drain_req`=1: `res_ready`=0 throughout, three `fb` cycles, then `drain_done`=1. Dropping `drain_req` resumes grants in the next cycle.
- `flush` asserted with the FIFO full and `res_valid` set: no `fb` and no grant in that cycle; FIFO empty next cycle; `coalesce_cnt` unchanged.
